// File: rtl/bg_signal_detector.sv
// Background-noise signal detector: per-lane threshold, run confirm, holdoff.
// Optional peak tracking is enabled with macro BG_DET_PEAK_EN.
module bg_signal_detector #(
  parameter int SCALE_SHIFT     = 4,
  parameter int THR_MARGIN      = 64,
  parameter int MIN_LANES       = 4,
  parameter int CONFIRM_PERIODS = 3,
  parameter int HOLDOFF_PERIODS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] period_data,
  input  logic [255:0] noise,
  output logic         det_active,
  output logic         event_valid,
  input  logic         event_ready,
  output logic [15:0]  event_mask,
  output logic [15:0]  event_index,
`ifdef BG_DET_PEAK_EN
  output logic [8:0]   event_peak,
  output logic [3:0]   event_peak_lane,
`endif
  output logic [4:0]   event_hits
);

  typedef enum logic [1:0] {
    IDLE, CAND, DETECT, HOLDOFF
  } state_t;

  state_t      state, state_n;
  logic        accept;
  logic [15:0] hit_c;
  logic [4:0]  cnt_c;
  logic [15:0] pidx;
  logic        s1_valid;
  logic [15:0] s1_mask;
  logic [4:0]  s1_hits;
  logic [15:0] s1_index;
  logic        active;
  logic [15:0] run, run_n;
  logic [15:0] hcnt, hcnt_n;
  logic [15:0] rmask, rmask_n;
  logic        emit;

  assign in_ready = !event_valid;
  assign accept   = in_valid && in_ready;

`ifdef BG_DET_PEAK_EN
  logic [15:0][8:0] mag_c;
  logic [8:0]       pk_c, s1_pk, rpk, rpk_n, mpk;
  logic [3:0]       pl_c, s1_pl, rpl, rpl_n, mpl;
  logic             better;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_lane
    logic [7:0]  s;
    logic [15:0] n;
    logic [8:0]  sx;
    logic [8:0]  mag;
    logic [14:0] nz;
    logic [17:0] lhs;
    logic [17:0] rhs;
    assign s   = period_data[8*g +: 8];
    assign n   = noise[16*g +: 16];
    assign sx  = {s[7], s};
    assign mag = s[7] ? (~sx + 9'd1) : sx;
    assign nz  = n[15] ? 15'd0 : n[14:0];
    assign lhs = 18'(mag) << SCALE_SHIFT;
    assign rhs = 18'(nz) + 18'(THR_MARGIN);
    assign hit_c[g] = lhs > rhs;
`ifdef BG_DET_PEAK_EN
    assign mag_c[g] = mag;
`endif
  end

  // Popcount of the per-lane hits for the incoming beat
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < 16; i++)
      cnt_c = cnt_c + {4'd0, hit_c[i]};
  end

`ifdef BG_DET_PEAK_EN
  // Beat peak magnitude; strict compare keeps the lowest lane on ties
  always_comb begin
    pk_c = '0;
    pl_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (mag_c[i] > pk_c) begin
        pk_c = mag_c[i];
        pl_c = 4'(i);
      end
    end
  end
`endif

  // Stage 1: register the beat summary and advance the period index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      s1_hits  <= '0;
      s1_index <= '0;
      pidx     <= '0;
`ifdef BG_DET_PEAK_EN
      s1_pk    <= '0;
      s1_pl    <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mask  <= hit_c;
        s1_hits  <= cnt_c;
        s1_index <= pidx;
        pidx     <= pidx + 16'd1;
`ifdef BG_DET_PEAK_EN
        s1_pk    <= pk_c;
        s1_pl    <= pl_c;
`endif
      end
    end
  end

  assign active     = s1_hits >= 5'(MIN_LANES);
  assign det_active = (state == DETECT) || (state == HOLDOFF);

`ifdef BG_DET_PEAK_EN
  assign better = (s1_pk > rpk) || ((s1_pk == rpk) && (s1_pl < rpl));
  assign mpk    = better ? s1_pk : rpk;
  assign mpl    = better ? s1_pl : rpl;
`endif

  // Stage 2: detection FSM next-state and run bookkeeping
  always_comb begin
    state_n = state;
    run_n   = run;
    hcnt_n  = hcnt;
    rmask_n = rmask;
    emit    = 1'b0;
`ifdef BG_DET_PEAK_EN
    rpk_n   = rpk;
    rpl_n   = rpl;
`endif
    if (s1_valid) begin
      unique case (state)
        IDLE: begin
          if (active) begin
            run_n   = 16'd1;
            rmask_n = s1_mask;
`ifdef BG_DET_PEAK_EN
            rpk_n   = s1_pk;
            rpl_n   = s1_pl;
`endif
            if (CONFIRM_PERIODS == 1) begin
              state_n = DETECT;
              emit    = 1'b1;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (active) begin
            run_n   = run + 16'd1;
            rmask_n = rmask | s1_mask;
`ifdef BG_DET_PEAK_EN
            rpk_n   = mpk;
            rpl_n   = mpl;
`endif
            if (run + 16'd1 >= 16'(CONFIRM_PERIODS)) begin
              state_n = DETECT;
              emit    = 1'b1;
            end
          end else begin
            state_n = IDLE;
            run_n   = '0;
            rmask_n = '0;
`ifdef BG_DET_PEAK_EN
            rpk_n   = '0;
            rpl_n   = '0;
`endif
          end
        end
        DETECT: begin
          if (!active) begin
            if (HOLDOFF_PERIODS == 1) begin
              state_n = IDLE;
              run_n   = '0;
              rmask_n = '0;
`ifdef BG_DET_PEAK_EN
              rpk_n   = '0;
              rpl_n   = '0;
`endif
            end else begin
              state_n = HOLDOFF;
              hcnt_n  = 16'd1;
            end
          end
        end
        HOLDOFF: begin
          if (active) begin
            state_n = DETECT;
            hcnt_n  = '0;
          end else begin
            hcnt_n = hcnt + 16'd1;
            if (hcnt + 16'd1 >= 16'(HOLDOFF_PERIODS)) begin
              state_n = IDLE;
              hcnt_n  = '0;
              run_n   = '0;
              rmask_n = '0;
`ifdef BG_DET_PEAK_EN
              rpk_n   = '0;
              rpl_n   = '0;
`endif
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state and run registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= '0;
      hcnt  <= '0;
      rmask <= '0;
`ifdef BG_DET_PEAK_EN
      rpk   <= '0;
      rpl   <= '0;
`endif
    end else begin
      state <= state_n;
      run   <= run_n;
      hcnt  <= hcnt_n;
      rmask <= rmask_n;
`ifdef BG_DET_PEAK_EN
      rpk   <= rpk_n;
      rpl   <= rpl_n;
`endif
    end
  end

  // Event register: load on emit, hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_valid <= 1'b0;
      event_mask  <= '0;
      event_index <= '0;
      event_hits  <= '0;
`ifdef BG_DET_PEAK_EN
      event_peak      <= '0;
      event_peak_lane <= '0;
`endif
    end else if (emit) begin
      event_valid <= 1'b1;
      event_mask  <= rmask | s1_mask;
      event_index <= s1_index;
      event_hits  <= s1_hits;
`ifdef BG_DET_PEAK_EN
      event_peak      <= mpk;
      event_peak_lane <= mpl;
`endif
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bg_signal_detector.sv
// Directed testbench for bg_signal_detector.
// Checks confirm, thresholds, broken runs, holdoff, backpressure and reset.
module tb_bg_signal_detector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] period_data;
  logic [255:0] noise;
  logic         det_active;
  logic         event_valid;
  logic         event_ready;
  logic [15:0]  event_mask;
  logic [15:0]  event_index;
  logic [4:0]   event_hits;
`ifdef BG_DET_PEAK_EN
  logic [8:0]   event_peak;
  logic [3:0]   event_peak_lane;
`endif

  always #5 clk = ~clk;

  bg_signal_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .period_data (period_data),
    .noise       (noise),
    .det_active  (det_active),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_mask  (event_mask),
    .event_index (event_index),
`ifdef BG_DET_PEAK_EN
    .event_peak      (event_peak),
    .event_peak_lane (event_peak_lane),
`endif
    .event_hits  (event_hits)
  );

  int ntest = 0;
  int nfail = 0;
  int ev_cnt = 0;
  int base;
  logic [15:0] lm = '0;
  logic [15:0] li = '0;
  logic [4:0]  lh = '0;

  always @(posedge clk) begin
    if (rst_n && event_valid && event_ready) begin
      ev_cnt <= ev_cnt + 1;
      lm     <= event_mask;
      li     <= event_index;
      lh     <= event_hits;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] m,
                                      input logic [7:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (m[i]) r[8*i +: 8] = v;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] d);
    int w;
    w = 0;
    period_data = d;
    in_valid    = 1'b1;
    while (!in_ready && w < 50) begin
      tick(1);
      w++;
    end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [127:0] d, input int n);
    repeat (n) send(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, z;
    a = mk(16'h001F, 8'd11);
    z = '0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    event_ready = 1'b1;
    period_data = '0;
    noise       = {16{16'd100}};
    #1;
    tick(3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_event_valid", 32'(event_valid), 32'd0);
    chk("rst_det_active", 32'(det_active), 32'd0);
    chk("rst_event_mask", 32'(event_mask), 32'd0);
    chk("rst_event_index", 32'(event_index), 32'd0);
    chk("rst_event_hits", 32'(event_hits), 32'd0);
    rst_n = 1'b1;

    // basic confirm, event held by backpressure
    base = ev_cnt;
    event_ready = 1'b0;
    send_n(a, 3);
    chk("basic_latency_early", 32'(event_valid), 32'd0);
    tick(1);
    chk("basic_valid", 32'(event_valid), 32'd1);
    chk("basic_mask", 32'(event_mask), 32'h001F);
    chk("basic_hits", 32'(event_hits), 32'd5);
    chk("basic_index", 32'(event_index), 32'd2);
    chk("basic_det", 32'(det_active), 32'd1);

    // backpressure for 10 cycles with a beat offered
    in_valid = 1'b1;
    period_data = a;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(event_valid), 32'd1);
      chk("bp_mask", 32'(event_mask), 32'h001F);
      chk("bp_index", 32'(event_index), 32'd2);
      chk("bp_hits", 32'(event_hits), 32'd5);
    end
    in_valid = 1'b0;
    event_ready = 1'b1;
    tick(1);
    chk("bp_release_valid", 32'(event_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("basic_event_count", 32'(ev_cnt - base), 32'd1);

    // holdoff: 7 inactive then 1 active keeps detection alive
    base = ev_cnt;
    send_n(z, 7);
    send(a);
    chk("hold_det_after7", 32'(det_active), 32'd1);
    send_n(z, 8);
    chk("hold_det_before8", 32'(det_active), 32'd1);
    tick(1);
    chk("hold_det_fall", 32'(det_active), 32'd0);
    chk("hold_no_event", 32'(ev_cnt - base), 32'd0);
    send_n(a, 3);
    tick(2);
    chk("second_event_count", 32'(ev_cnt - base), 32'd1);
    chk("second_event_index", 32'(li), 32'd21);
    chk("second_event_mask", 32'(lm), 32'h001F);
    send_n(z, 8);
    tick(1);
    chk("second_det_fall", 32'(det_active), 32'd0);

    // sub-threshold and too few lanes
    base = ev_cnt;
    send_n(mk(16'hFFFF, 8'd10), 3);
    send_n(mk(16'h0007, 8'd11), 3);
    tick(3);
    chk("subthr_no_event", 32'(ev_cnt - base), 32'd0);
    chk("subthr_det", 32'(det_active), 32'd0);

    // -128 against negative noise clamps to zero
    noise = {16{16'hFFFB}};
    send_n(mk(16'h000F, 8'h80), 3);
    tick(2);
    chk("neg_event_count", 32'(ev_cnt - base), 32'd1);
    chk("neg_event_mask", 32'(lm), 32'h000F);
    chk("neg_event_hits", 32'(lh), 32'd4);
    chk("neg_event_index", 32'(li), 32'd38);
    send_n(z, 8);
    tick(1);
    chk("neg_det_fall", 32'(det_active), 32'd0);
    noise = {16{16'd100}};

    // reset with a pending event
    event_ready = 1'b0;
    send_n(a, 3);
    tick(1);
    chk("pend_valid", 32'(event_valid), 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst2_valid", 32'(event_valid), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    chk("rst2_det", 32'(det_active), 32'd0);
    chk("rst2_mask", 32'(event_mask), 32'd0);
    chk("rst2_index", 32'(event_index), 32'd0);
    chk("rst2_hits", 32'(event_hits), 32'd0);

    // reset during a candidate run of 2
    event_ready = 1'b1;
    send_n(a, 2);
    tick(1);
    chk("cand_det", 32'(det_active), 32'd0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst3_det", 32'(det_active), 32'd0);
    chk("rst3_in_ready", 32'(in_ready), 32'd1);

    // broken run from index 0
    base = ev_cnt;
    send_n(mk(16'hFF00, 8'd11), 2);
    send(z);
    send(mk(16'h001F, 8'd11));
    send(mk(16'h003E, 8'd11));
    send(mk(16'h000F, 8'd11));
    chk("broken_no_early", 32'(ev_cnt - base), 32'd0);
    tick(2);
    chk("broken_count", 32'(ev_cnt - base), 32'd1);
    chk("broken_index", 32'(li), 32'd5);
    chk("broken_mask", 32'(lm), 32'h003F);
    chk("broken_hits", 32'(lh), 32'd4);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
